// File: rtl/adder_op_issuer.sv
// Sequencer driving a fixed-latency pipelined signed adder core: accepts
// one add/sub request at a time, enables the core, captures its result.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b/in_sub
// request port; core_ce/core_a/core_b/core_valid/core_s core port;
// out_valid/out_ready/out_sum/out_ovf/out_err result port.
module adder_op_issuer #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             core_ce,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic             core_valid,
  input  logic [WIDTH-1:0] core_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            sub_q;
  logic            sb_q;
  logic            sa;
  logic            ss;
  logic            ovf;

  assign in_ready  = (state == IDLE);
  assign core_ce   = (state == ISSUE);
  assign out_valid = (state == DONE);

  // Overflow uses the sign of the original B, so subtracting the most
  // negative value (whose negation is itself) is still flagged correctly.
  assign sa  = core_a[WIDTH-1];
  assign ss  = core_s[WIDTH-1];
  assign ovf = sub_q ? ((sa != sb_q) && (ss != sa))
                     : ((sa == sb_q) && (ss != sa));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      core_a  <= '0;
      core_b  <= '0;
      sub_q   <= 1'b0;
      sb_q    <= 1'b0;
      out_sum <= '0;
      out_ovf <= 1'b0;
      out_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            core_a <= in_a;
            core_b <= in_sub ? (~in_b + 1'b1) : in_b;
            sub_q  <= in_sub;
            sb_q   <= in_b[WIDTH-1];
            cnt    <= '0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          // A result arriving on the last watchdog cycle still wins.
          if (core_valid) begin
            out_sum <= core_s;
            out_ovf <= ovf;
            out_err <= 1'b0;
            state   <= DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            out_sum <= '0;
            out_ovf <= 1'b0;
            out_err <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_op_issuer.sv
// Scoreboard bench for adder_op_issuer with a 6-cycle core model.
// Directed corner cases followed by randomized add/sub traffic.
module tb_adder_op_issuer;

  localparam int W  = 64;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         core_ce;
  logic [W-1:0] core_a;
  logic [W-1:0] core_b;
  logic         core_valid;
  logic [W-1:0] core_s;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_ovf;
  logic         out_err;

  adder_op_issuer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .core_ce(core_ce), .core_a(core_a), .core_b(core_b),
    .core_valid(core_valid), .core_s(core_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Core model: valid in the 7th consecutive ce-high cycle.
  bit           stuck = 1'b0;
  bit           stray = 1'b0;
  logic [W-1:0] garbage = '0;
  int           ce_cnt = 0;
  always @(posedge clk) ce_cnt <= core_ce ? ce_cnt + 1 : 0;
  assign core_valid = (core_ce && ce_cnt == 6 && !stuck) || stray;
  assign core_s = stray ? garbage : core_a + core_b;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b2;
    logic [W-1:0] sum;
    logic         ovf;
    logic         err;
    int           t;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         ovf;
  } res_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   rdy_mode = 2;

  // Wide signed arithmetic: overflow iff the exact result does not fit.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s);
    logic signed [W:0] wa, wb, r;
    res_t o;
    wa = $signed({a[W-1], a});
    wb = $signed({b[W-1], b});
    r = s ? wa - wb : wa + wb;
    o.sum = r[W-1:0];
    o.ovf = r[W] ^ r[W-1];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout/unexpected expected event", nm);
  endtask

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'($urandom_range(0, 1));
        1: out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard checker
  int cur_run = 0;
  int last_run = 0;
  bit prev_ov = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      cur_run = 0;
      prev_ov = 1'b0;
    end else begin
      if (core_ce) begin
        cur_run++;
        chk("busy_in_ready", in_ready, 0);
        if (q.size() == 0) fail("ce_without_op");
        else begin
          chk("core_a", core_a, q[0].a);
          chk("core_b", core_b, q[0].b2);
        end
      end else if (cur_run != 0) begin
        last_run = cur_run;
        cur_run = 0;
      end
      if (out_valid) begin
        if (q.size() == 0) fail("result_without_op");
        else begin
          if (!prev_ov) begin
            chk("latency", W'(cycle - q[0].t), q[0].err ? W'(TO + 1) : W'(8));
            chk("ce_run", W'(last_run), q[0].err ? W'(TO) : W'(7));
          end
          chk("out_sum", out_sum, q[0].sum);
          chk("out_ovf", out_ovf, q[0].ovf);
          chk("out_err", out_err, q[0].err);
          chk("done_in_ready", in_ready, 0);
          chk("done_core_ce", core_ce, 0);
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input bit stk);
    int n;
    exp_t e;
    res_t m;
    n = 0;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        fail("in_ready_wait");
        return;
      end
      @(negedge clk);
    end
    m = model(a, b, s);
    e.a   = a;
    e.b2  = s ? -b : b;
    e.sum = stk ? '0 : m.sum;
    e.ovf = stk ? 1'b0 : m.ovf;
    e.err = stk;
    e.t   = cycle;
    q.push_back(e);
    stuck = stk;
    in_a = a;
    in_b = b;
    in_sub = s;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0) begin
      n++;
      if (n > 300) begin
        fail("drain_wait");
        q.delete();
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_core_ce"}, core_ce, 0);
    chk({tag, "_core_a"}, core_a, 0);
    chk({tag, "_core_b"}, core_b, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_sum"}, out_sum, 0);
    chk({tag, "_out_ovf"}, out_ovf, 0);
    chk({tag, "_out_err"}, out_err, 0);
  endtask

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0: v = '0;
      1: v = {1'b0, {(W-1){1'b1}}};
      2: v = {1'b1, {(W-1){1'b0}}};
      3: v = '1;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  localparam logic [W-1:0] MINNEG = {1'b1, {(W-1){1'b0}}};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("rst");

    rdy_mode = 2;
    issue(64'd5, 64'd7, 1'b0, 1'b0);
    wait_empty();
    issue(MINNEG, 64'd1, 1'b1, 1'b0);
    wait_empty();
    issue(64'd0, MINNEG, 1'b1, 1'b0);
    wait_empty();

    // Backpressure with ignored request pulses and a stray core pulse
    rdy_mode = 1;
    @(posedge clk);
    #2;
    issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!out_valid) fail("bp_out_valid_wait");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_a = {$urandom, $urandom};
      in_b = {$urandom, $urandom};
      stray = (i == 5);
      garbage = {$urandom, $urandom};
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    stray = 1'b0;
    rdy_mode = 2;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);

    // Stray core pulse while idle
    @(posedge clk);
    #1 stray = 1'b1;
    garbage = {$urandom, $urandom};
    @(posedge clk);
    #1 stray = 1'b0;
    @(negedge clk);
    chk("stray_idle_in_ready", in_ready, 1);
    chk("stray_idle_out_valid", out_valid, 0);
    chk("stray_idle_core_ce", core_ce, 0);

    // Watchdog
    issue({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b1);
    wait_empty();

    // Reset in the middle of ISSUE
    issue(64'd1, 64'd2, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_state("midrst");
    issue(-64'd3, -64'd4, 1'b0, 1'b0);
    wait_empty();

    // Random traffic
    rdy_mode = 0;
    for (int i = 0; i < 1000; i++) begin
      issue(rnd_val(), rnd_val(), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) == 0));
    end
    rdy_mode = 2;
    wait_empty();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_op_issuer.md
# adder_op_issuer

Initiator-side sequencer for the fixed-latency pipelined signed adder core: accepts add/subtract requests on a valid/ready port, drives the core's clock-enable and operand bus, waits for the core's one-cycle valid pulse, then holds the captured sum and a signed-overflow flag on a valid/ready result port. A watchdog reports an error if the core never responds. Sits between Chisel-side datapath logic and the adder core wrapper; one operation is in flight at a time.

## Interface
- WIDTH, 64, operand/sum width in bits (two's complement)
- TIMEOUT, 16, max cycles in ISSUE before declaring error (must be > 7)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  1 = A - B, 0 = A + B
- core_ce  out  1  clock enable to adder core
- core_a  out  WIDTH  operand A to core (registered)
- core_b  out  WIDTH  operand B' to core (registered)
- core_valid  in  1  one-cycle result pulse from core
- core_s  in  WIDTH  core sum, sampled only when core_valid & core_ce
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- out_sum  out  WIDTH  captured sum
- out_ovf  out  1  signed overflow of the requested operation
- out_err  out  1  watchdog fired; out_sum = 0, out_ovf = 0

## Operation
- States: IDLE, ISSUE, DONE. in_ready = (state == IDLE); core_ce = (state == ISSUE); out_valid = (state == DONE).
- IDLE: on in_valid: core_a <= in_a; core_b <= in_sub ? (~in_b + 1) mod 2^WIDTH : in_b; latch in_sub and sign of in_b; cnt <= 0; -> ISSUE.
- ISSUE: core_a/core_b held stable. If core_valid: out_sum <= core_s, out_err <= 0, out_ovf computed, -> DONE. Else if cnt == TIMEOUT-1: out_sum <= 0, out_ovf <= 0, out_err <= 1, -> DONE. Else cnt <= cnt + 1. core_valid wins if both occur same cycle.
- DONE: outputs held stable until out_valid & out_ready, then -> IDLE. No bypass: next request accepted no earlier than the cycle after the handshake.
- Overflow (uses original B sign sb, A sign sa, sum sign ss): add: ovf = (sa == sb) & (ss != sa); sub: ovf = (sa != sb) & (ss != sa). Covers B = most-negative on subtract.
- core_valid outside ISSUE is ignored (no state/output change).
- Reset: state IDLE, core_ce 0, core_a/core_b 0, cnt 0, out_valid 0, out_sum 0, out_ovf 0, out_err 0. Reset during ISSUE drops core_ce the next cycle; the core's own valid tracking clears when ce is low.

## Timing
- Request accepted at edge ending cycle T; core_ce high from cycle T+1.
- Core asserts core_valid after 6 consecutive ce-high cycles: high in cycle T+7; sum captured at end of T+7; core_ce low and out_valid high from T+8. Accept-to-result latency 8 cycles.
- With out_ready tied high: DONE for 1 cycle, IDLE at T+9; max throughput one op per 9 cycles.
- Timeout: core_ce high for exactly TIMEOUT cycles (T+1..T+TIMEOUT), out_valid with out_err at T+TIMEOUT+1.
- core_ce never high for fewer than 1 or more than TIMEOUT consecutive cycles; core_a/core_b never change while core_ce is high.

## Test plan
- Add: A=5, B=7, sub=0, core model 6-cycle latency -> core_ce high 7 cycles, out_valid at T+8, out_sum=12, ovf=0, err=0.
- Sub with overflow: A=0x8000_0000_0000_0000, B=1, sub=1 -> core_b=0xFFFF_FFFF_FFFF_FFFF, out_sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1; also A=0, B=0x8000_0000_0000_0000, sub=1 -> out_sum=0x8000_0000_0000_0000, ovf=1.
- Backpressure: out_ready low 10 cycles after result -> out_* stable, in_ready low, in_valid pulses ignored; result released on first out_ready cycle, IDLE next cycle.
- Watchdog: core_valid stuck 0 -> core_ce high exactly 16 cycles, out_err=1, out_sum=0; stray core_valid in DONE/IDLE changes nothing.
- Reset at T+4 during ISSUE -> core_ce=0 and all outputs 0 next cycle; subsequent A=-3, B=-4, sub=0 -> out_sum=-7, ovf=0, latency 8.
- Back-to-back random add/sub (1000 ops, random out_ready) vs. reference model: sums and ovf match, one op in flight.
